// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the stack CPU and the host loader. Grants are combinational (0 cycles); read data follows 1 cycle later.
// Contention is resolved round-robin. Host bursts are capped at MAX_BURST while the CPU waits. A loser stays stalled until it is granted.
module ram_arbiter #(
   parameter int DW        = 16,
   parameter int AW        = 12,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] rdata,
   output logic          ram_load,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q,
   output logic [15:0]   cpu_stall
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CPU_OWN   = 2'd1;
   localparam logic [1:0] HOST_OWN  = 2'd2;
   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [3:0]    burst_cnt;
   logic [AW-1:0] addr_hold;
   logic [DW-1:0] d_hold;
   logic [DW-1:0] rdata_hold;

   // Grants are forced low while reset is asserted, so nothing reaches the RAM during reset.
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (reset) begin
         if (cpu_req && host_req) begin
            if (state == CPU_OWN)
               host_gnt = 1'b1;
            else if (state == HOST_OWN && burst_cnt < BURST_LIM)
               host_gnt = 1'b1;
            else
               cpu_gnt = 1'b1;
         end else begin
            cpu_gnt  = cpu_req;
            host_gnt = host_req;
         end
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (cpu_gnt)
         state_nxt = CPU_OWN;
      else if (host_gnt)
         state_nxt = HOST_OWN;
   end

   always_comb begin
      ram_addr = addr_hold;
      ram_d    = d_hold;
      ram_load = 1'b0;
      if (cpu_gnt) begin
         ram_addr = cpu_addr;
         ram_d    = cpu_wdata;
         ram_load = cpu_we;
      end else if (host_gnt) begin
         ram_addr = host_addr;
         ram_d    = host_wdata;
         ram_load = host_we;
      end
   end

   assign rdata = (cpu_rvalid || host_rvalid) ? ram_q : rdata_hold;

   // The burst counter only advances while the CPU is waiting, so host-only traffic is never throttled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         burst_cnt   <= 4'd0;
         addr_hold   <= '0;
         d_hold      <= '0;
         rdata_hold  <= '0;
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         cpu_stall   <= 16'd0;
      end else begin
         state       <= state_nxt;
         addr_hold   <= ram_addr;
         d_hold      <= ram_d;
         rdata_hold  <= rdata;
         cpu_rvalid  <= cpu_gnt && !cpu_we;
         host_rvalid <= host_gnt && !host_we;
         if (host_gnt && cpu_req) begin
            if (burst_cnt != 4'hF)
               burst_cnt <= burst_cnt + 4'd1;
         end else begin
            burst_cnt <= 4'd0;
         end
         if (cpu_req && !cpu_gnt && cpu_stall != 16'hFFFF)
            cpu_stall <= cpu_stall + 16'd1;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic, scored against a rule-level model and shadow memory.
module tb_ram_arbiter;
   localparam int DW = 16;
   localparam int AW = 12;
   localparam int MB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          cpu_req, cpu_we, host_req, host_we;
   logic [AW-1:0] cpu_addr, host_addr;
   logic [DW-1:0] cpu_wdata, host_wdata;

   logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, ram_load;
   logic [DW-1:0] rdata, ram_d, ram_q;
   logic [AW-1:0] ram_addr;
   logic [15:0]   cpu_stall;

   logic          cpu_gnt1, cpu_rvalid1, host_gnt1, host_rvalid1, ram_load1;
   logic [DW-1:0] rdata1, ram_d1, ram_q1;
   logic [AW-1:0] ram_addr1;
   logic [15:0]   cpu_stall1;

   ram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .rdata(rdata), .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
      .cpu_stall(cpu_stall));

   ram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt1), .host_rvalid(host_rvalid1),
      .rdata(rdata1), .ram_load(ram_load1), .ram_addr(ram_addr1), .ram_d(ram_d1), .ram_q(ram_q1),
      .cpu_stall(cpu_stall1));

   logic [DW-1:0] mem0 [4096];
   logic [DW-1:0] mem1 [4096];
   logic [DW-1:0] ref_mem [4096];

   always @(posedge clk) begin
      if (ram_load) mem0[ram_addr] <= ram_d;
      ram_q <= mem0[ram_addr];
   end
   always @(posedge clk) begin
      if (ram_load1) mem1[ram_addr1] <= ram_d1;
      ram_q1 <= mem1[ram_addr1];
   end

   // Reference model: who won last cycle, host wins since the CPU started waiting, and pending read data.
   int            last_winner;   // 0 none, 1 cpu, 2 host
   int            host_streak;
   int            m_stall;
   bit            m_pc, m_ph;
   logic [DW-1:0] m_data, m_hold;
   bit            eg, eh;
   logic          og_cpu, og_host;
   int            n_chk = 0;
   int            n_pass = 0;

   int            w, hp, n, st0;
   bit            cdone, pending;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return 12'hFFF;
      return 12'($urandom_range(0, 7));
   endfunction

   // Called just after a falling edge with inputs already driven; checks, then advances to the next falling edge.
   task automatic cyc();
      bit host_wins;
      #1;
      if (!reset) begin
         last_winner = 0; host_streak = 0; m_stall = 0;
         m_pc = 0; m_ph = 0; m_hold = '0;
      end
      host_wins = (last_winner == 1) || (last_winner == 2 && host_streak < MB);
      eg = reset && cpu_req && (!host_req || !host_wins);
      eh = reset && host_req && !eg;
      og_cpu  = cpu_gnt;
      og_host = host_gnt;
      chk("cpu_gnt",     32'(cpu_gnt),     32'(eg));
      chk("host_gnt",    32'(host_gnt),    32'(eh));
      chk("cpu_rvalid",  32'(cpu_rvalid),  32'(m_pc));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_ph));
      chk("rdata",       32'(rdata),       32'((m_pc || m_ph) ? m_data : m_hold));
      chk("cpu_stall",   32'(cpu_stall),   32'(m_stall));
      chk("ram_load",    32'(ram_load),    32'((eg && cpu_we) || (eh && host_we)));
      if (eg || eh) chk("ram_addr", 32'(ram_addr), 32'(eg ? cpu_addr : host_addr));

      if (m_pc || m_ph) m_hold = m_data;
      m_pc = eg && !cpu_we;
      m_ph = eh && !host_we;
      if (eg) begin
         if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         else m_data = ref_mem[cpu_addr];
      end
      if (eh) begin
         if (host_we) ref_mem[host_addr] = host_wdata;
         else m_data = ref_mem[host_addr];
      end
      if (reset && cpu_req && !eg && m_stall < 65535) m_stall++;
      if (eh && cpu_req) host_streak = (host_streak < 15) ? host_streak + 1 : 15;
      else host_streak = 0;
      last_winner = eg ? 1 : (eh ? 2 : 0);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      last_winner = 0; host_streak = 0; m_stall = 0; m_pc = 0; m_ph = 0;
      m_data = '0; m_hold = '0;
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = 16'(i) ^ 16'h5A5A;
         mem1[i] = 16'(i) ^ 16'h5A5A;
         ref_mem[i] = 16'(i) ^ 16'h5A5A;
      end
      mem0[12'h010] = 16'h1234;
      mem1[12'h010] = 16'h1234;
      ref_mem[12'h010] = 16'h1234;

      @(negedge clk);
      cyc();
      chk("t1_reset_stall", 32'(cpu_stall), 32'd0);
      chk("t1_reset_rvalid", 32'(cpu_rvalid | host_rvalid), 32'd0);
      cyc();
      reset = 1'b1;

      // Reset lands while a host read is in flight.
      host_req = 1; host_we = 0; host_addr = 12'h005;
      cyc();
      reset = 1'b0;
      cyc();
      chk("t1_gnt_in_reset", 32'(host_gnt), 32'd0);
      chk("t1_rvalid_in_reset", 32'(host_rvalid), 32'd0);
      reset = 1'b1; host_req = 0;
      cyc();
      chk("t1_no_stale_rvalid", 32'(host_rvalid), 32'd0);

      // CPU-only read.
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
      cyc();
      chk("t2_cpu_gnt", 32'(og_cpu), 32'd1);
      cpu_req = 0;
      #1;
      chk("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("t2_rdata", 32'(rdata), 32'h1234);
      cyc();

      // Simultaneous requests from idle.
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
      host_req = 1; host_we = 0; host_addr = 12'h030;
      cyc();
      chk("t3_cpu_first", 32'(og_cpu), 32'd1);
      cpu_req = 0;
      cyc();
      chk("t3_host_second", 32'(og_host), 32'd1);
      host_req = 0;
      #1;
      chk("t3_host_rvalid", 32'(host_rvalid), 32'd1);
      chk("t3_host_rdata", 32'(rdata), 32'h5A6A);
      cyc();

      // Host burst of 10 writes with the CPU arriving at word 2.
      w = 0; hp = 0; n = 0; cdone = 0; st0 = m_stall;
      while (w < 10 && n < 40) begin
         host_req = 1; host_we = 1; host_addr = 12'(100 + w); host_wdata = 16'(w * 4369);
         cpu_req = (w >= 2 && !cdone); cpu_we = 0; cpu_addr = 12'h200;
         pending = cpu_req;
         cyc();
         if (og_host) begin
            w++;
            if (pending) hp++;
         end
         if (og_cpu) cdone = 1;
         n++;
      end
      host_req = 0; cpu_req = 0;
      cyc();
      chk("t4_host_grants_while_cpu_waits", 32'(hp), 32'd4);
      chk("t4_cpu_served", 32'(cdone), 32'd1);
      chk("t4_cpu_stall", 32'(cpu_stall), 32'(st0 + 4));

      // Write to the top address, then read it back on the next cycle.
      host_req = 1; host_we = 1; host_addr = 12'hFFF; host_wdata = 16'hBEEF;
      cyc();
      host_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'hFFF;
      cyc();
      cpu_req = 0;
      #1;
      chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("t5_rdata_wrap", 32'(rdata), 32'hBEEF);
      cyc();

      // MAX_BURST=1 instance: strict alternation under permanent contention.
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cpu_req = 1; cpu_we = 0; cpu_addr = 12'h001;
         host_req = 1; host_we = 0; host_addr = 12'h002;
         #1;
         chk("t6_cpu_gnt1", 32'(cpu_gnt1), 32'(i % 2 == 0));
         chk("t6_host_gnt1", 32'(host_gnt1), 32'(i % 2 == 1));
         chk("t6_stall1", 32'(cpu_stall1), 32'(i / 2));
         cyc();
      end
      cpu_req = 0; host_req = 0;
      cyc();

      // Randomized traffic; each side holds its request until granted.
      for (int i = 0; i < 400; i++) begin
         if (!cpu_req && $urandom_range(0, 2) != 0) begin
            cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
         end
         if (!host_req && $urandom_range(0, 3) != 0) begin
            host_req = 1; host_we = 1'($urandom_range(0, 1));
            host_addr = rand_addr(); host_wdata = 16'($urandom);
         end
         cyc();
         if (og_cpu) cpu_req = 0;
         if (og_host) host_req = 0;
      end
      cpu_req = 0; host_req = 0;
      cyc();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
